// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// button_conditioner_pkg
// Shared types and constants for the push-button conditioning block.
//   rpt_state_t    : per-channel auto-repeat FSM state encoding
//   DEF_*          : default timing constants for a 100 MHz system clock
//   cnt_width()    : width of a counter that must hold 0..max_count (min 1 bit)
// -----------------------------------------------------------------------------
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    localparam int DEF_N_BTN           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
    localparam int DEF_REPEAT_DELAY    = 30_000_000;  // 300 ms
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;  // 100 ms

    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One button: 2-flop synchroniser, debounce filter and hold-to-repeat FSM.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   raw    in   raw asynchronous button pin (active high)
//   level  out  debounced button state
//   press  out  1-cycle pulse on debounced press and on each auto-repeat
//   rel    out  1-cycle pulse on debounced release
// -----------------------------------------------------------------------------
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

    localparam logic [CW-1:0] DB_LAST = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
    localparam logic [RW-1:0] RD_LAST = RW'((REPEAT_DELAY    > 0) ? REPEAT_DELAY    - 1 : 0);
    localparam logic [RW-1:0] RP_LAST = RW'((REPEAT_PERIOD   > 0) ? REPEAT_PERIOD   - 1 : 0);

    logic          s1, s2;
    logic          db;
    logic [CW-1:0] cnt;
    logic          db_accept, db_rise, db_fall;

    rpt_state_t    state, state_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    logic          press_nxt, rel_nxt;

    // --- stage: synchroniser + debounce ---
    // db flips on the edge where the mismatch has persisted DEBOUNCE_CYCLES
    // consecutive cycles; any agreeing cycle clears the run.
    assign db_accept = (s2 != db) && (cnt == DB_LAST);
    assign db_rise   = db_accept &  s2;
    assign db_fall   = db_accept & ~s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == db) begin
                cnt <= '0;
            end else if (db_accept) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // --- stage: repeat FSM ---
    // Press/release pulses are registered on the same edge that db changes,
    // so they line up with the btn_level transition. Release wins over a
    // repeat pulse falling on the same edge.
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        if (db_fall) begin
            state_nxt = IDLE;
            rcnt_nxt  = '0;
            rel_nxt   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (db_rise) begin
                        press_nxt = 1'b1;
                        rcnt_nxt  = '0;
                        state_nxt = DELAY;
                    end
                end
                DELAY: begin
                    if (REPEAT_DELAY == 0) begin
                        // Repeat disabled: park here until release.
                        rcnt_nxt = '0;
                    end else if (rcnt == RD_LAST) begin
                        press_nxt = 1'b1;
                        rcnt_nxt  = '0;
                        state_nxt = REPEAT;
                    end else begin
                        rcnt_nxt = rcnt + RW'(1);
                    end
                end
                REPEAT: begin
                    if (rcnt == RP_LAST) begin
                        press_nxt = 1'b1;
                        rcnt_nxt  = '0;
                    end else begin
                        rcnt_nxt = rcnt + RW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    rcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rcnt  <= '0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
            press <= press_nxt;
            rel   <= rel_nxt;
        end
    end

    assign level = db;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions raw player push-buttons for the paddle logic: per-button
// synchronise/debounce/edge/auto-repeat, plus up/down conflict cancellation.
// Pair k is bits {2k (up), 2k+1 (down)}.
// Ports:
//   clk          in   system clock (100 MHz)
//   reset        in   asynchronous active-high reset
//   btn_raw      in   raw asynchronous button pins, active high
//   btn_level    out  debounced button state
//   btn_press    out  1-cycle pulse on press and on each auto-repeat
//   btn_release  out  1-cycle pulse on release
//   move_level   out  pair-cancelled level, one cycle behind btn_level
// -----------------------------------------------------------------------------
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] move_level
);

    genvar i;
    generate
        for (i = 0; i < N_BTN; i++) begin : g_ch
            button_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_ch (
                .clk   (clk),
                .reset (reset),
                .raw   (btn_raw[i]),
                .level (btn_level[i]),
                .press (btn_press[i]),
                .rel   (btn_release[i])
            );
        end
    endgenerate

    // --- stage: pair cancellation ---
    // Holding both directions of a pair means "no motion" on either.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            move_level <= '0;
        end else begin
            for (int k = 0; k < N_BTN / 2; k++) begin
                move_level[2*k]   <= btn_level[2*k]   & ~btn_level[2*k+1];
                move_level[2*k+1] <= btn_level[2*k+1] & ~btn_level[2*k];
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int NB = 4;
    localparam int DC = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level, btn_press, btn_release, move_level;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN           (NB),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .move_level  (move_level)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: raw delayed two samples, a level that flips once the
    // delayed input has disagreed for DC consecutive samples, and a press
    // schedule derived from the age of the current hold.
    logic [NB-1:0] m_s1, m_s2, m_lvl, m_press, m_rel, m_move;
    int            m_run [NB];
    int            m_age [NB];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0; m_move = '0;
        for (int i = 0; i < NB; i++) begin
            m_run[i] = 0;
            m_age[i] = -1;
        end
    endtask

    task automatic model_step();
        logic [NB-1:0] old_lvl;
        old_lvl = m_lvl;
        m_press = '0;
        m_rel   = '0;
        for (int k = 0; k < NB / 2; k++) begin
            m_move[2*k]   = old_lvl[2*k]   & ~old_lvl[2*k+1];
            m_move[2*k+1] = old_lvl[2*k+1] & ~old_lvl[2*k];
        end
        for (int i = 0; i < NB; i++) begin
            if (m_s2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DC) begin
                    m_lvl[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            if (!old_lvl[i] && m_lvl[i]) begin
                m_press[i] = 1'b1;
                m_age[i]   = 0;
            end else if (old_lvl[i] && !m_lvl[i]) begin
                m_rel[i] = 1'b1;
                m_age[i] = -1;
            end else if (m_age[i] >= 0) begin
                m_age[i]++;
                if (RD > 0 && (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RP == 0)))
                    m_press[i] = 1'b1;
            end
        end
        m_s2 = m_s1;
        m_s1 = btn_raw;
    endtask

    task automatic check_all();
        chk("level",   32'(btn_level),   32'(m_lvl));
        chk("press",   32'(btn_press),   32'(m_press));
        chk("release", 32'(btn_release), 32'(m_rel));
        chk("move",    32'(move_level),  32'(m_move));
        chk("press_and_release", 32'(btn_press & btn_release), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        #1;
        check_all();
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
    endtask

    task automatic settle_idle();
        btn_raw = '0;
        repeat (14) tick();
    endtask

    logic [20:0] pr;
    logic        acc;
    int          k_found;
    int          hold;

    initial begin
        reset   = 1'b1;
        btn_raw = 4'b1111;
        model_reset();
        #1;

        // Reset with all buttons held, then fresh detection 6 edges later.
        repeat (3) tick();
        chk("t1_reset_outs", 32'({btn_level, btn_press, btn_release, move_level}), 32'd0);
        reset = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 5) chk("t1_lvl_e5", 32'(btn_level), 32'd0);
            if (e == 6) begin
                chk("t1_lvl_e6",   32'(btn_level), 32'hF);
                chk("t1_press_e6", 32'(btn_press), 32'hF);
            end
        end
        tick();
        chk("t1_press_e7", 32'(btn_press), 32'd0);
        settle_idle();

        // Short glitch on bit 0 is filtered.
        acc = 1'b0;
        btn_raw[0] = 1'b1;
        repeat (3) begin tick(); acc = acc | btn_level[0] | btn_press[0] | btn_release[0]; end
        btn_raw[0] = 1'b0;
        repeat (10) begin tick(); acc = acc | btn_level[0] | btn_press[0] | btn_release[0]; end
        chk("t2_glitch", 32'(acc), 32'd0);

        // Hold bit 1: press at T, repeats at T+8, T+11, ...
        btn_raw[1] = 1'b1;
        k_found = 0;
        for (int k = 1; k <= 20 && k_found == 0; k++) begin
            tick();
            if (btn_press[1]) k_found = k;
        end
        chk("t3_first_press_lat", 32'(k_found), 32'd6);
        pr = '0;
        pr[0] = btn_press[1];
        for (int j = 1; j <= 20; j++) begin
            tick();
            pr[j] = btn_press[1];
        end
        chk("t3_press_pattern", 32'(pr), 32'(21'b1_0010_0100_1001_0000_0001));
        btn_raw[1] = 1'b0;
        k_found = 0;
        for (int k = 1; k <= 12 && k_found == 0; k++) begin
            tick();
            if (btn_release[1]) begin
                k_found = k;
                chk("t3_no_press_on_rel", 32'(btn_press[1]), 32'd0);
            end
        end
        chk("t3_release_lat", 32'(k_found), 32'd6);
        settle_idle();

        // Both buttons of pair 1 held, then drop the down button.
        btn_raw[3:2] = 2'b11;
        repeat (10) tick();
        chk("t4_lvl_both",  32'(btn_level[3:2]),  32'd3);
        chk("t4_move_both", 32'(move_level[3:2]), 32'd0);
        btn_raw[3] = 1'b0;
        k_found = 0;
        for (int k = 1; k <= 12 && k_found == 0; k++) begin
            tick();
            if (!btn_level[3]) k_found = k;
        end
        chk("t4_lvl3_fall_lat", 32'(k_found), 32'd6);
        chk("t4_move2_same",    32'(move_level[2]), 32'd0);
        tick();
        chk("t4_move2_next",    32'(move_level[2]), 32'd1);
        settle_idle();

        // Bit 0 chatters every 2 cycles while bit 1 is held.
        acc = 1'b0;
        btn_raw[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c % 2 == 0) btn_raw[0] = ~btn_raw[0];
            tick();
            acc = acc | btn_level[0] | btn_press[0] | btn_release[0];
        end
        btn_raw[0] = 1'b0;
        repeat (4) begin tick(); acc = acc | btn_level[0] | btn_press[0] | btn_release[0]; end
        chk("t5_chatter", 32'(acc), 32'd0);
        chk("t5_bit1_held", 32'(btn_level[1]), 32'd1);
        settle_idle();

        // Reset during DELAY on bit 1.
        btn_raw[1] = 1'b1;
        k_found = 0;
        for (int k = 1; k <= 20 && k_found == 0; k++) begin
            tick();
            if (btn_press[1]) k_found = k;
        end
        chk("t6_press_seen", 32'(k_found), 32'd6);
        repeat (5) tick();
        assert_reset();
        chk("t6_reset_outs", 32'({btn_level, btn_press, btn_release, move_level}), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        k_found = 0;
        for (int k = 1; k <= 12 && k_found == 0; k++) begin
            tick();
            if (btn_press[1]) k_found = k;
        end
        chk("t6_fresh_press_lat", 32'(k_found), 32'd6);
        k_found = 0;
        for (int k = 1; k <= 12 && k_found == 0; k++) begin
            tick();
            if (btn_press[1]) k_found = k;
        end
        chk("t6_first_repeat", 32'(k_found), 32'd8);
        settle_idle();

        // Random segments with occasional long holds and mid-stream resets.
        for (int s = 0; s < 150; s++) begin
            btn_raw = 4'($urandom);
            hold = ($urandom_range(0, 4) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 8);
            if ($urandom_range(0, 29) == 0) begin
                assert_reset();
                tick();
                reset = 1'b0;
            end
            repeat (hold) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
